// File: rtl/adc_spi_sampler.sv
// Free-running sampler for an external 8-channel, 10-bit SPI ADC.
// Define ADC_SAMPLE_AVG_EN to strobe only the truncated mean of 4 same-channel conversions.
module adc_spi_sampler #(
    parameter int CLK_DIV = 8,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] channel,
    output logic       new_sample,
    output logic [9:0] sample,
    output logic [3:0] sample_channel,
    output logic       busy,
    output logic       adc_cs_n,
    output logic       adc_sck,
    output logic       adc_mosi,
    input  logic       adc_miso
);

    // 17 SCK periods are halves 0..33; half 34 is the trailing low time before DONE.
    localparam int LAST_HALF = 34;
    localparam int GW        = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [1:0] {GAP, START, SHIFT, DONE} state_t;

    state_t        state;
    state_t        next_state;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    div_cnt;
    logic [5:0]    half_cnt;
    logic [2:0]    chan_q;
    logic [3:0]    cmd_q;
    logic [9:0]    shreg;
    logic          div_wrap;
    logic          gap_done;
    logic          shift_done;

`ifdef ADC_SAMPLE_AVG_EN
    logic [11:0] acc;
    logic [1:0]  acc_cnt;
    logic [2:0]  prev_chan;
    logic [11:0] acc_sum;

    assign acc_sum = acc + {2'b00, shreg};
`endif

    assign div_wrap   = (div_cnt == 8'(CLK_DIV - 1));
    assign gap_done   = (gap_cnt == GW'(CS_GAP - 1));
    assign shift_done = (state == SHIFT) && div_wrap && (half_cnt == 6'(LAST_HALF));

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            GAP:     if (gap_done) next_state = START;
            START:   next_state = channel[3] ? GAP : SHIFT;
            SHIFT:   if (shift_done) next_state = DONE;
            DONE:    next_state = GAP;
            default: next_state = GAP;
        endcase
    end

    // NOTE: all state updates use <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= GAP;
            gap_cnt        <= '0;
            div_cnt        <= '0;
            half_cnt       <= '0;
            chan_q         <= '0;
            cmd_q          <= '0;
            shreg          <= '0;
            adc_cs_n       <= 1'b1;
            adc_sck        <= 1'b0;
            adc_mosi       <= 1'b0;
            busy           <= 1'b0;
            new_sample     <= 1'b0;
            sample         <= '0;
            sample_channel <= '0;
`ifdef ADC_SAMPLE_AVG_EN
            acc            <= '0;
            acc_cnt        <= '0;
            prev_chan      <= '0;
`endif
        end else begin
            state      <= next_state;
            adc_cs_n   <= (next_state != SHIFT);
            busy       <= (next_state == SHIFT);
            new_sample <= 1'b0;

            case (state)
                GAP: gap_cnt <= gap_done ? '0 : gap_cnt + GW'(1);
                START: begin
                    if (!channel[3]) begin
                        chan_q   <= channel[2:0];
                        cmd_q    <= {1'b1, channel[2:0]};
                        adc_mosi <= 1'b1;
                        adc_sck  <= 1'b0;
                        div_cnt  <= '0;
                        half_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (!div_wrap) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (half_cnt != 6'(LAST_HALF)) begin
                            half_cnt <= half_cnt + 6'd1;
                            adc_sck  <= ~half_cnt[0];
                            if (!half_cnt[0]) begin
                                // Rising edge number half_cnt/2+1; data bits ride on edges 8..17.
                                if (half_cnt >= 6'd14) shreg <= {shreg[8:0], adc_miso};
                            end else begin
                                adc_mosi <= cmd_q[3];
                                cmd_q    <= {cmd_q[2:0], 1'b0};
                            end
                        end
                    end
                end
                default: ;
            endcase

            if (shift_done) begin
`ifdef ADC_SAMPLE_AVG_EN
                prev_chan <= chan_q;
                if (acc_cnt == 2'd0 || chan_q != prev_chan) begin
                    acc     <= {2'b00, shreg};
                    acc_cnt <= 2'd1;
                end else if (acc_cnt == 2'd3) begin
                    new_sample     <= 1'b1;
                    sample         <= acc_sum[11:2];
                    sample_channel <= {1'b0, chan_q};
                    acc            <= '0;
                    acc_cnt        <= 2'd0;
                end else begin
                    acc     <= acc_sum;
                    acc_cnt <= acc_cnt + 2'd1;
                end
`else
                new_sample     <= 1'b1;
                sample         <= shreg;
                sample_channel <= {1'b0, chan_q};
`endif
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Self-checking bench for adc_spi_sampler with a behavioural SPI ADC and a frame-level reference model.
`timescale 1ns/1ps
module tb_adc_spi_sampler;

    localparam int CLK_DIV       = 2;
    localparam int CS_GAP        = 4;
    localparam int LOW_CYCLES    = 17 * 2 * CLK_DIV + CLK_DIV;
    localparam int FRAME_PERIOD  = LOW_CYCLES + CS_GAP + 2;
`ifdef ADC_SAMPLE_AVG_EN
    localparam int N_AVG = 4;
`else
    localparam int N_AVG = 1;
`endif
    localparam int STROBE_PERIOD = FRAME_PERIOD * N_AVG;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] channel = 4'd0;
    logic       adc_miso = 1'b0;
    logic       new_sample;
    logic [9:0] sample;
    logic [3:0] sample_channel;
    logic       busy;
    logic       adc_cs_n;
    logic       adc_sck;
    logic       adc_mosi;

    always #5 clk = ~clk;

    adc_spi_sampler #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk            (clk),
        .rst            (rst),
        .channel        (channel),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .busy           (busy),
        .adc_cs_n       (adc_cs_n),
        .adc_sck        (adc_sck),
        .adc_mosi       (adc_mosi),
        .adc_miso       (adc_miso)
    );

    typedef struct {
        int         cyc;
        logic [9:0] value;
        logic [3:0] chan;
    } strobe_t;

    strobe_t strobes[$];
    strobe_t expected[$];
    int      adc_vals[$];
    int      asserts = 0;
    int      fails   = 0;
    int      cyc     = 0;

    always @(posedge clk) cyc++;

    // Reference model: one result per complete frame, optionally averaged in groups of 4.
    int m_sum, m_cnt, m_prev;

    function automatic void model_reset();
        m_sum  = 0;
        m_cnt  = 0;
        m_prev = -1;
    endfunction

    function automatic void model_frame(input int value, input int chan);
        strobe_t e;
        e.cyc = 0;
        e.chan = 4'(chan);
        if (N_AVG == 1) begin
            e.value = 10'(value);
            expected.push_back(e);
        end else begin
            if (m_cnt == 0 || chan != m_prev) begin
                m_sum = value;
                m_cnt = 1;
            end else begin
                m_sum += value;
                m_cnt++;
                if (m_cnt == N_AVG) begin
                    e.value = 10'(m_sum / N_AVG);
                    expected.push_back(e);
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
            m_prev = chan;
        end
    endfunction

    // Behavioural ADC: samples command bits on rising SCK, shifts data out on falling SCK.
    int         edge_cnt = 0;
    int         low_cnt  = 0;
    int         frame_ch = 0;
    int         cs_falls = 0;
    logic [4:0] cmd_bits = '0;
    logic [9:0] cur_val  = '0;

    always @(negedge adc_cs_n) begin
        edge_cnt = 0;
        low_cnt  = 0;
        cmd_bits = '0;
        cs_falls++;
        frame_ch = int'(channel);
        cur_val  = (adc_vals.size() > 0) ? 10'(adc_vals.pop_front()) : 10'($urandom_range(0, 1023));
    end

    always @(negedge clk) if (adc_cs_n === 1'b0) low_cnt++;

    always @(posedge adc_sck) begin
        if (adc_cs_n === 1'b0) begin
            edge_cnt++;
            if (edge_cnt <= 5) cmd_bits = {cmd_bits[3:0], adc_mosi};
        end
    end

    always @(negedge adc_sck) begin
        if (adc_cs_n === 1'b0)
            adc_miso = (edge_cnt >= 7 && edge_cnt <= 16) ? cur_val[16 - edge_cnt] : 1'b0;
    end

    always @(posedge adc_cs_n) begin
        if (edge_cnt == 17) begin
            asserts++;
            if (cmd_bits !== {2'b11, 3'(frame_ch)} || low_cnt != LOW_CYCLES) begin
                fails++;
                $display("FAIL frame_format: cmd=%b cs_low=%0d, expected cmd=%b cs_low=%0d",
                         cmd_bits, low_cnt, {2'b11, 3'(frame_ch)}, LOW_CYCLES);
            end
            model_frame(int'(cur_val), frame_ch);
        end
        adc_miso = 1'b0;
    end

    // Strobe monitor: records strobes and checks spacing and hold behaviour.
    logic       prev_strobe = 1'b0;
    logic [9:0] last_sample = '0;
    logic [3:0] last_chan   = '0;

    always @(negedge clk) begin
        strobe_t s;
        if (rst) begin
            if (new_sample) begin
                s.cyc = cyc;
                s.value = sample;
                s.chan = sample_channel;
                strobes.push_back(s);
                asserts++;
                if (prev_strobe) begin
                    fails++;
                    $display("FAIL strobe_spacing: new_sample high on consecutive cycles at cycle %0d", cyc);
                end
            end else if (sample !== last_sample || sample_channel !== last_chan) begin
                asserts++;
                fails++;
                $display("FAIL output_hold: sample=%h chan=%0d changed without strobe, was %h/%0d",
                         sample, sample_channel, last_sample, last_chan);
            end
        end
        prev_strobe = new_sample;
        last_sample = sample;
        last_chan   = sample_channel;
    end

    task automatic apply_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        strobes.delete();
        expected.delete();
        adc_vals.delete();
        model_reset();
    endtask

    task automatic wait_strobes(input int n, input string name);
        int budget = (n + 1) * STROBE_PERIOD + 20;
        while (strobes.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (strobes.size() < n) begin
            asserts++;
            fails++;
            $display("FAIL %s_timeout: got %0d strobes, required %0d", name, strobes.size(), n);
        end
    endtask

    task automatic wait_edge(input int e, input string name);
        int budget = 2 * FRAME_PERIOD + 10;
        while (!(adc_cs_n === 1'b0 && edge_cnt == e) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            asserts++;
            fails++;
            $display("FAIL %s_edge_timeout: sck edge %0d, required %0d", name, edge_cnt, e);
        end
    endtask

    task automatic wait_falls(input int n, input string name);
        int budget = (n + 1) * FRAME_PERIOD + 10;
        while (cs_falls < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (cs_falls < n) begin
            asserts++;
            fails++;
            $display("FAIL %s_frame_timeout: frames %0d, required %0d", name, cs_falls, n);
        end
    endtask

    task automatic check_strobes(input string name);
        asserts++;
        if (strobes.size() != expected.size()) begin
            fails++;
            $display("FAIL %s_count: got %0d strobes, expected %0d", name, strobes.size(), expected.size());
        end
        for (int i = 0; i < strobes.size() && i < expected.size(); i++) begin
            asserts++;
            if (strobes[i].value !== expected[i].value || strobes[i].chan !== expected[i].chan) begin
                fails++;
                $display("FAIL %s_strobe%0d: got %h ch %0d, expected %h ch %0d", name, i,
                         strobes[i].value, strobes[i].chan, expected[i].value, expected[i].chan);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        asserts++;
        if ({adc_cs_n, adc_sck, adc_mosi, new_sample, sample, sample_channel, busy} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: cs_n=%b sck=%b mosi=%b strobe=%b sample=%h chan=%0d busy=%b, expected 1 0 0 0 000 0 0",
                     adc_cs_n, adc_sck, adc_mosi, new_sample, sample, sample_channel, busy);
        end
    endtask

    task automatic test_first_frame();
        int budget = FRAME_PERIOD;
        apply_reset();
        channel = 4'd5;
        repeat (N_AVG) adc_vals.push_back('h2A5);
        rst = 1'b1;
        while (adc_cs_n !== 1'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        asserts++;
        if ({adc_cs_n, busy, adc_sck, adc_mosi} !== 4'b0101) begin
            fails++;
            $display("FAIL frame_start: cs_n=%b busy=%b sck=%b mosi=%b, expected 0 1 0 1",
                     adc_cs_n, busy, adc_sck, adc_mosi);
        end
        wait_strobes(1, "first");
        asserts++;
        if (strobes.size() > 0 && (strobes[0].value !== 10'h2A5 || strobes[0].chan !== 4'd5)) begin
            fails++;
            $display("FAIL first_sample: got %h ch %0d, expected 2a5 ch 5", strobes[0].value, strobes[0].chan);
        end
        check_strobes("first");
    endtask

    task automatic test_steady();
        apply_reset();
        channel = 4'd3;
        repeat (N_AVG) adc_vals.push_back('h3FF);
        repeat (N_AVG) adc_vals.push_back('h001);
        rst = 1'b1;
        wait_strobes(4, "steady");
        asserts++;
        if (strobes.size() >= 2 && (strobes[0].value !== 10'h3FF || strobes[1].value !== 10'h001 ||
                                    strobes[0].chan !== 4'd3 || strobes[1].chan !== 4'd3)) begin
            fails++;
            $display("FAIL steady_values: got %h/%0d %h/%0d, expected 3ff/3 001/3",
                     strobes[0].value, strobes[0].chan, strobes[1].value, strobes[1].chan);
        end
        for (int i = 1; i < strobes.size(); i++) begin
            asserts++;
            if (strobes[i].cyc - strobes[i-1].cyc != STROBE_PERIOD) begin
                fails++;
                $display("FAIL steady_period%0d: got %0d cycles, expected %0d", i,
                         strobes[i].cyc - strobes[i-1].cyc, STROBE_PERIOD);
            end
        end
        check_strobes("steady");
    endtask

    task automatic test_invalid();
        int falls0;
        apply_reset();
        channel = 4'd9;
        rst = 1'b1;
        falls0 = cs_falls;
        repeat (3 * FRAME_PERIOD) @(negedge clk);
        asserts++;
        if (cs_falls != falls0 || strobes.size() != 0) begin
            fails++;
            $display("FAIL invalid_channel: got %0d frames %0d strobes, expected 0 0",
                     cs_falls - falls0, strobes.size());
        end
        channel = 4'd2;
        wait_strobes(1, "invalid_recover");
        asserts++;
        if (strobes.size() > 0 && strobes[0].chan !== 4'd2) begin
            fails++;
            $display("FAIL invalid_recover_chan: got %0d, expected 2", strobes[0].chan);
        end
        check_strobes("invalid");
    endtask

    task automatic test_channel_change();
        apply_reset();
        channel = 4'd0;
        rst = 1'b1;
        wait_edge(3, "chan_change");
        channel = 4'd6;
        wait_strobes((N_AVG == 1) ? 2 : 1, "chan_change");
`ifndef ADC_SAMPLE_AVG_EN
        asserts++;
        if (strobes.size() >= 2 && (strobes[0].chan !== 4'd0 || strobes[1].chan !== 4'd6)) begin
            fails++;
            $display("FAIL chan_change_order: got %0d then %0d, expected 0 then 6",
                     strobes[0].chan, strobes[1].chan);
        end
`endif
        check_strobes("chan_change");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        channel = 4'($urandom_range(0, 7));
        rst = 1'b1;
        wait_edge(10, "reset_mid");
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        asserts++;
        if ({adc_cs_n, adc_sck, busy, new_sample} !== 4'b1000 || strobes.size() != 0) begin
            fails++;
            $display("FAIL reset_mid_abort: cs_n=%b sck=%b busy=%b strobe=%b strobes=%0d, expected 1 0 0 0 0",
                     adc_cs_n, adc_sck, busy, new_sample, strobes.size());
        end
        @(negedge clk);
        rst = 1'b1;
        wait_strobes(1, "reset_mid");
        check_strobes("reset_mid");
    endtask

    task automatic test_random();
        apply_reset();
        channel = 4'($urandom_range(0, 7));
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_edge($urandom_range(1, 16), "random");
            channel = 4'($urandom_range(0, 7));
        end
        repeat (2 * FRAME_PERIOD) @(negedge clk);
        check_strobes("random");
    endtask

`ifdef ADC_SAMPLE_AVG_EN
    task automatic test_avg();
        int falls0;
        apply_reset();
        channel = 4'd1;
        adc_vals.push_back(100);
        adc_vals.push_back(101);
        adc_vals.push_back(102);
        adc_vals.push_back(103);
        falls0 = cs_falls;
        rst = 1'b1;
        wait_strobes(1, "avg");
        asserts++;
        if (strobes.size() > 0 && (strobes[0].value !== 10'd101 || strobes[0].chan !== 4'd1)) begin
            fails++;
            $display("FAIL avg_mean: got %0d ch %0d, expected 101 ch 1", strobes[0].value, strobes[0].chan);
        end
        wait_falls(falls0 + 6, "avg");
        wait_edge(2, "avg");
        channel = 4'd4;
        wait_falls(falls0 + 10, "avg");
        asserts++;
        if (strobes.size() != 1) begin
            fails++;
            $display("FAIL avg_restart: got %0d strobes before 4 new-channel frames, expected 1", strobes.size());
        end
        wait_strobes(2, "avg_new");
        asserts++;
        if (strobes.size() >= 2 && strobes[1].chan !== 4'd4) begin
            fails++;
            $display("FAIL avg_new_chan: got %0d, expected 4", strobes[1].chan);
        end
        check_strobes("avg");
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_steady();
        test_invalid();
        test_channel_change();
        test_reset_mid();
        test_random();
`ifdef ADC_SAMPLE_AVG_EN
        test_avg();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Producer end of the channel/new_sample/sample/sample_channel interface used by analog-input consumers.
- Accepts a requested channel from the consumer and drives an external 8-channel, 10-bit SPI ADC.
- Presents each result as a one-cycle new_sample strobe with its 10-bit value and the channel it belongs to.
- Free-running: converts back-to-back, re-reading the requested channel before each conversion.

Parameters:
- CLK_DIV, 8: clk cycles per SCK half-period; legal range 2..255.
- CS_GAP, 4: clk cycles adc_cs_n is held high between conversions; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- channel  in  4  requested channel from the consumer; valid values 0..7
- new_sample  out  1  one-cycle strobe marking a fresh result
- sample  out  10  conversion result; held between strobes
- sample_channel  out  4  channel the current sample belongs to
- busy  out  1  high while a conversion frame is in progress
- adc_cs_n  out  1  ADC chip select, active-low
- adc_sck  out  1  SPI clock; idles low
- adc_mosi  out  1  command bits to the ADC
- adc_miso  in  1  data from the ADC

Behaviour:
- Reset (rst==0 at a clk edge):
  - adc_cs_n=1, adc_sck=0, adc_mosi=0, new_sample=0, sample=0, sample_channel=0, busy=0.
  - FSM goes to GAP with the gap counter cleared.
  - Reset mid-frame aborts the frame: cs_n is high on the next cycle and no strobe is issued.
- FSM states: GAP -> START -> SHIFT -> DONE -> GAP.
- GAP:
  - cs_n high; counts CS_GAP cycles, then goes to START.
- START (1 cycle):
  - If channel[3]==1, the request is invalid: return to GAP and restart the gap count. No frame, no strobe.
  - Otherwise latch channel[2:0] into chan_q, load the command word, and go to SHIFT.
  - Command word order: 1, 1, chan_q[2], chan_q[1], chan_q[0], then 0s.
- SHIFT:
  - cs_n low, busy high, adc_mosi = command bit 1.
  - SCK low for CLK_DIV cycles, then high for CLK_DIV cycles; this repeats for 17 SCK periods.
  - Rising edges are numbered 1..17.
  - adc_mosi changes only when SCK goes low, and holds command bit k+1 after falling edge k.
  - adc_miso is captured on the clk cycle in which SCK goes high, for edges 8..17 only, MSB first (edge 8 = B9, edge 17 = B0).
  - After the high half of period 17: SCK goes low, then stays low for a further CLK_DIV cycles; then go to DONE.
- DONE (1 cycle):
  - adc_cs_n=1, busy=0, new_sample=1.
  - sample <= captured shift register; sample_channel <= {1'b0, chan_q}.
  - Outputs update in the same cycle new_sample is high; the consumer samples them together.
  - Next state GAP.
- Frame timing:
  - cs_n low for 17*2*CLK_DIV + CLK_DIV cycles.
  - Strobe period with a steady valid channel = that value + CS_GAP + 2.
- Channel changes:
  - A change during SHIFT affects only the next frame.
  - The current frame completes with chan_q.
- new_sample is never high on two consecutive cycles.
- sample and sample_channel change only in DONE.

Optional Feature:
- Macro: ADC_SAMPLE_AVG_EN.
- Defined:
  - Accumulate 4 consecutive conversions of the same chan_q in a 12-bit sum.
  - DONE asserts new_sample only on the 4th conversion, with sample = sum[11:2] (truncating); the accumulator then clears.
  - If chan_q differs from the previous frame's channel, the accumulator restarts with the new result as conversion 1 of 4.
  - Reset clears the accumulator and count.
- Undefined:
  - Every frame strobes; no accumulator logic is present.

Test Plan:
- Reset then release, CLK_DIV=2, CS_GAP=4, channel=5 -> adc_mosi bits on rising edges 1..5 read 1,1,1,0,1. An ADC model returns 10'h2A5, so new_sample pulses once with sample=10'h2A5 and sample_channel=5. cs_n low for exactly 70 cycles.
- Steady channel=3, ADC model returns 10'h3FF then 10'h001 -> strobes exactly 76 cycles apart with samples 10'h3FF then 10'h001, both with sample_channel=3.
- channel=4'd9 held -> cs_n never goes low and new_sample never asserts. Switching to channel=2 gives the first strobe with sample_channel=2.
- Channel changed 0->6 at SCK edge 3 of a frame -> that frame reports sample_channel=0; the next frame sends 1,1,1,1,0 and reports 6.
- rst pulled low at SCK edge 10 -> next cycle cs_n=1, sck=0, busy=0, no strobe. After release, a full clean frame completes.
- ADC_SAMPLE_AVG_EN, channel=1, ADC model returns 100,101,102,103 -> a single strobe with sample=101. A channel change after 2 frames gives no strobe until 4 frames on the new channel.
